// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Opcodes, sequencer states, ALU function codes and IR field positions.
// Rev    : 1.0
// ============================================================================
package cpu_pkg;

  localparam int OPC_WIDTH   = 5;
  localparam int REG_FIELD_W = 4;
  localparam int IR_OPC_MSB  = 31;
  localparam int IR_RA_LSB   = 23;
  localparam int IR_RB_LSB   = 19;
  localparam int IR_RC_LSB   = 15;

  localparam logic [OPC_WIDTH-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_WIDTH-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_WIDTH-1:0] OPC_OR   = 5'b00101;
  localparam logic [OPC_WIDTH-1:0] OPC_SHR  = 5'b00110;
  localparam logic [OPC_WIDTH-1:0] OPC_AND  = 5'b00111;
  localparam logic [OPC_WIDTH-1:0] OPC_SHL  = 5'b01000;
  localparam logic [OPC_WIDTH-1:0] OPC_ROR  = 5'b01001;
  localparam logic [OPC_WIDTH-1:0] OPC_ROL  = 5'b01010;
  localparam logic [OPC_WIDTH-1:0] OPC_ADDI = 5'b01011;
  localparam logic [OPC_WIDTH-1:0] OPC_ANDI = 5'b01100;
  localparam logic [OPC_WIDTH-1:0] OPC_ORI  = 5'b01101;
  localparam logic [OPC_WIDTH-1:0] OPC_MUL  = 5'b01110;
  localparam logic [OPC_WIDTH-1:0] OPC_DIV  = 5'b01111;
  localparam logic [OPC_WIDTH-1:0] OPC_NEG  = 5'b10000;
  localparam logic [OPC_WIDTH-1:0] OPC_NOT  = 5'b10001;
  localparam logic [OPC_WIDTH-1:0] OPC_NOP  = 5'b11000;
  localparam logic [OPC_WIDTH-1:0] OPC_HALT = 5'b11001;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_ROR = 4'd6;
  localparam logic [3:0] ALU_ROL = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;
  localparam logic [3:0] ALU_NEG = 4'd10;
  localparam logic [3:0] ALU_NOT = 4'd11;

  // S_IDLE is the Stop hold: strobes quiet but the core still counts as running.
  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8,
    S_IDLE = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    CLS_RALU   = 3'd0,
    CLS_IMM    = 3'd1,
    CLS_MULDIV = 3'd2,
    CLS_UNARY  = 3'd3,
    CLS_NOP    = 3'd4,
    CLS_HALT   = 3'd5,
    CLS_ILL    = 3'd6
  } opclass_e;

  function automatic opclass_e op_class(input logic [OPC_WIDTH-1:0] opc);
    case (opc)
      OPC_ADD, OPC_SUB, OPC_OR, OPC_SHR,
      OPC_AND, OPC_SHL, OPC_ROR, OPC_ROL: op_class = CLS_RALU;
      OPC_ADDI, OPC_ANDI, OPC_ORI:        op_class = CLS_IMM;
      OPC_MUL, OPC_DIV:                   op_class = CLS_MULDIV;
      OPC_NEG, OPC_NOT:                   op_class = CLS_UNARY;
      OPC_NOP:                            op_class = CLS_NOP;
      OPC_HALT:                           op_class = CLS_HALT;
      default:                            op_class = CLS_ILL;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input logic [OPC_WIDTH-1:0] opc);
    case (opc)
      OPC_SUB:            alu_code = ALU_SUB;
      OPC_AND, OPC_ANDI:  alu_code = ALU_AND;
      OPC_OR, OPC_ORI:    alu_code = ALU_OR;
      OPC_SHR:            alu_code = ALU_SHR;
      OPC_SHL:            alu_code = ALU_SHL;
      OPC_ROR:            alu_code = ALU_ROR;
      OPC_ROL:            alu_code = ALU_ROL;
      OPC_MUL:            alu_code = ALU_MUL;
      OPC_DIV:            alu_code = ALU_DIV;
      OPC_NEG:            alu_code = ALU_NEG;
      OPC_NOT:            alu_code = ALU_NOT;
      default:            alu_code = ALU_ADD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/select_encode.sv
`default_nettype none
// ============================================================================
// Module : select_encode
// Picks Ra/Rb/Rc and turns it into one-hot register write/drive enables.
// Rev    : 1.0
// ============================================================================
module select_encode
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [REG_FIELD_W-1:0] ra_i,
  input  logic [REG_FIELD_W-1:0] rb_i,
  input  logic [REG_FIELD_W-1:0] rc_i,
  input  logic                   gra_i,
  input  logic                   grb_i,
  input  logic                   grc_i,
  input  logic                   rin_en_i,
  input  logic                   rout_en_i,
  output logic [NUM_REGS-1:0]    rin_o,
  output logic [NUM_REGS-1:0]    rout_o
);

  logic [REG_FIELD_W-1:0] sel;
  logic                   any_sel;

  always_comb begin
    sel = '0;
    if (gra_i)      sel = ra_i;
    else if (grb_i) sel = rb_i;
    else if (grc_i) sel = rc_i;
  end

  // Without a field select the enables stay quiet rather than defaulting to R0.
  assign any_sel = gra_i | grb_i | grc_i;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_onehot
    assign rin_o[i]  = rin_en_i  & any_sel & (sel == REG_FIELD_W'(i));
    assign rout_o[i] = rout_en_i & any_sel & (sel == REG_FIELD_W'(i));
  end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module : control_sequencer
// Hardwired fetch/decode/execute sequencer producing Moore datapath strobes.
// Rev    : 1.0
// ============================================================================
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Stop,
  input  logic [31:0]         IR,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                Zin,
  output logic                ZLOout,
  output logic                ZHIout,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                HIin,
  output logic                LOin,
  output logic                Cout,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [3:0]          ALUop,
  output logic                Run,
  output logic                Illegal
);

  state_e           state_q, state_d, done_st;
  logic [OPC_W-1:0] opcode;
  opclass_e         cls;
  logic [3:0]       alu_fn;
  logic             gra, grb, grc, rin_en, rout_en;
  logic             ir_unused;

  assign opcode    = IR[IR_OPC_MSB -: OPC_W];
  assign cls       = op_class(opcode);
  assign alu_fn    = alu_code(opcode);
  assign ir_unused = ^IR[IR_RC_LSB-1:0];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= S_RST;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = S_RST;
    done_st = Stop ? S_IDLE : S_T0;
    {PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read,
     MDRin, MDRout, IRin, Yin, HIin, LOin, Cout} = 15'b0;
    {gra, grb, grc, rin_en, rout_en} = 5'b0;
    ALUop   = ALU_ADD;
    Run     = 1'b1;
    Illegal = 1'b0;
    case (state_q)
      S_RST: begin
        Run     = 1'b0;
        state_d = done_st;
      end
      S_IDLE: state_d = done_st;
      S_T0: begin
        {PCout, MARin, IncPC, Zin} = 4'b1111;
        state_d = S_T1;
      end
      S_T1: begin
        {ZLOout, PCin, Read, MDRin} = 4'b1111;
        state_d = S_T2;
      end
      S_T2: begin
        {MDRout, IRin} = 2'b11;
        state_d = S_T3;
      end
      S_T3: begin
        case (cls)
          CLS_RALU, CLS_IMM: begin
            {grb, rout_en, Yin} = 3'b111;
            state_d = S_T4;
          end
          CLS_MULDIV: begin
            {gra, rout_en, Yin} = 3'b111;
            state_d = S_T4;
          end
          CLS_UNARY: begin
            {grb, rout_en, Zin} = 3'b111;
            ALUop   = alu_fn;
            state_d = S_T4;
          end
          CLS_NOP:  state_d = done_st;
          CLS_HALT: state_d = S_HALT;
          default: begin
            Illegal = 1'b1;
            state_d = done_st;
          end
        endcase
      end
      S_T4: begin
        state_d = S_T5;
        case (cls)
          CLS_RALU:   begin {grc, rout_en, Zin} = 3'b111; ALUop = alu_fn; end
          CLS_IMM:    begin {Cout, Zin} = 2'b11;          ALUop = alu_fn; end
          CLS_MULDIV: begin {grb, rout_en, Zin} = 3'b111; ALUop = alu_fn; end
          CLS_UNARY: begin
            {ZLOout, gra, rin_en} = 3'b111;
            state_d = done_st;
          end
          default: state_d = done_st;
        endcase
      end
      S_T5: begin
        state_d = done_st;
        case (cls)
          CLS_RALU, CLS_IMM: {ZLOout, gra, rin_en} = 3'b111;
          CLS_MULDIV: begin
            {ZLOout, LOin} = 2'b11;
            state_d = S_T6;
          end
          default: ;
        endcase
      end
      S_T6: begin
        {ZHIout, HIin} = 2'b11;
        state_d = done_st;
      end
      S_HALT: begin
        Run     = 1'b0;
        state_d = S_HALT;
      end
      default: begin
        Run     = 1'b0;
        state_d = S_RST;
      end
    endcase
  end

  select_encode #(
    .NUM_REGS (NUM_REGS)
  ) u_select_encode (
    .ra_i      (IR[IR_RA_LSB +: REG_FIELD_W]),
    .rb_i      (IR[IR_RB_LSB +: REG_FIELD_W]),
    .rc_i      (IR[IR_RC_LSB +: REG_FIELD_W]),
    .gra_i     (gra),
    .grb_i     (grb),
    .grc_i     (grc),
    .rin_en_i  (rin_en),
    .rout_en_i (rout_en),
    .rin_o     (Rin),
    .rout_o    (Rout)
  );

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_control_sequencer
// Directed stimulus pushes per-cycle expected strobes; a negedge monitor checks.
// Rev    : 1.0
// ============================================================================
module tb_control_sequencer;

  localparam int VW = 53;
  localparam logic [14:0] B_PCOUT  = 15'h4000;
  localparam logic [14:0] B_MARIN  = 15'h2000;
  localparam logic [14:0] B_INCPC  = 15'h1000;
  localparam logic [14:0] B_ZIN    = 15'h0800;
  localparam logic [14:0] B_ZLOOUT = 15'h0400;
  localparam logic [14:0] B_ZHIOUT = 15'h0200;
  localparam logic [14:0] B_PCIN   = 15'h0100;
  localparam logic [14:0] B_READ   = 15'h0080;
  localparam logic [14:0] B_MDRIN  = 15'h0040;
  localparam logic [14:0] B_MDROUT = 15'h0020;
  localparam logic [14:0] B_IRIN   = 15'h0010;
  localparam logic [14:0] B_YIN    = 15'h0008;
  localparam logic [14:0] B_HIIN   = 15'h0004;
  localparam logic [14:0] B_LOIN   = 15'h0002;
  localparam logic [14:0] B_COUT   = 15'h0001;

  logic        Clock, Resetn, Stop;
  logic [31:0] IR;
  logic PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read;
  logic MDRin, MDRout, IRin, Yin, HIin, LOin, Cout, Run, Illegal;
  logic [15:0] Rin, Rout;
  logic [3:0]  ALUop;

  control_sequencer #(.NUM_REGS(16), .OPC_W(5)) dut (
    .Clock(Clock), .Resetn(Resetn), .Stop(Stop), .IR(IR),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
    .ZLOout(ZLOout), .ZHIout(ZHIout), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .Cout(Cout), .Rin(Rin), .Rout(Rout),
    .ALUop(ALUop), .Run(Run), .Illegal(Illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    string           tag;
    logic [VW-1:0]   v;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_vec = 0;
  int            n_err = 0;
  logic [VW-1:0] act;

  assign act = {PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read,
                MDRin, MDRout, IRin, Yin, HIin, LOin, Cout,
                Rin, Rout, ALUop, Run, Illegal};

  function automatic logic [VW-1:0] ov(input logic [14:0] s, input logic [15:0] rin,
                                       input logic [15:0] rout, input logic [3:0] op,
                                       input logic run, input logic ill);
    return {s, rin, rout, op, run, ill};
  endfunction

  always @(negedge Clock) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      n_vec++;
      if (act !== mon_e.v) begin
        n_err++;
        $display("FAIL %s: got str=%h rin=%h rout=%h op=%0d run=%b ill=%b, expected str=%h rin=%h rout=%h op=%0d run=%b ill=%b",
                 mon_e.tag, act[52:38], act[37:22], act[21:6], act[5:2], act[1], act[0],
                 mon_e.v[52:38], mon_e.v[37:22], mon_e.v[21:6], mon_e.v[5:2], mon_e.v[1], mon_e.v[0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  task automatic push(input string tag, input logic [VW-1:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic fetch(input string t);
    push({t, ".T0"}, ov(B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0));
    push({t, ".T1"}, ov(B_ZLOOUT | B_PCIN | B_READ | B_MDRIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0));
    push({t, ".T2"}, ov(B_MDROUT | B_IRIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0));
  endtask

  // Register ALU / immediate: six cycles, T4 uses Cout instead of Rout[Rc] for immediates.
  task automatic alu_instr(input string t, input logic [31:0] ir, input logic imm,
                           input logic [3:0] op, input logic [15:0] ra,
                           input logic [15:0] rb, input logic [15:0] rc);
    IR = ir;
    fetch(t);
    push({t, ".T3"}, ov(B_YIN, 16'h0, rb, 4'd0, 1'b1, 1'b0));
    if (imm) push({t, ".T4"}, ov(B_COUT | B_ZIN, 16'h0, 16'h0, op, 1'b1, 1'b0));
    else     push({t, ".T4"}, ov(B_ZIN, 16'h0, rc, op, 1'b1, 1'b0));
    push({t, ".T5"}, ov(B_ZLOOUT, ra, 16'h0, 4'd0, 1'b1, 1'b0));
    ticks(6);
  endtask

  task automatic muldiv_instr(input string t, input logic [31:0] ir, input logic [3:0] op,
                              input logic [15:0] ra, input logic [15:0] rb);
    IR = ir;
    fetch(t);
    push({t, ".T3"}, ov(B_YIN, 16'h0, ra, 4'd0, 1'b1, 1'b0));
    push({t, ".T4"}, ov(B_ZIN, 16'h0, rb, op, 1'b1, 1'b0));
    push({t, ".T5"}, ov(B_ZLOOUT | B_LOIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0));
    push({t, ".T6"}, ov(B_ZHIOUT | B_HIIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0));
    ticks(7);
  endtask

  task automatic unary_instr(input string t, input logic [31:0] ir, input logic [3:0] op,
                             input logic [15:0] ra, input logic [15:0] rb);
    IR = ir;
    fetch(t);
    push({t, ".T3"}, ov(B_ZIN, 16'h0, rb, op, 1'b1, 1'b0));
    push({t, ".T4"}, ov(B_ZLOOUT, ra, 16'h0, 4'd0, 1'b1, 1'b0));
    ticks(5);
  endtask

  initial begin
    Resetn = 1'b0;
    Stop   = 1'b0;
    IR     = 32'h0;
    ticks(1);
    push("reset", ov(15'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0));
    Resetn = 1'b1;
    ticks(1);

    alu_instr("and",  32'h38918000, 1'b0, 4'd2, 16'h0002, 16'h0004, 16'h0008);
    alu_instr("addi", 32'h58900005, 1'b1, 4'd0, 16'h0002, 16'h0004, 16'h0000);
    muldiv_instr("mul", 32'h70900000, 4'd8, 16'h0002, 16'h0004);
    alu_instr("sub",  32'h20918000, 1'b0, 4'd1, 16'h0002, 16'h0004, 16'h0008);
    alu_instr("ror",  32'h4F870000, 1'b0, 4'd6, 16'h8000, 16'h0001, 16'h4000);
    alu_instr("shl",  32'h422B0000, 1'b0, 4'd5, 16'h0010, 16'h0020, 16'h0040);
    alu_instr("ori",  32'h6B3FFFFF, 1'b1, 4'd3, 16'h0040, 16'h0080, 16'h0000);
    muldiv_instr("div", 32'h79A00000, 4'd9, 16'h0008, 16'h0010);
    unary_instr("neg", 32'h82B80000, 4'd10, 16'h0020, 16'h0080);
    unary_instr("not", 32'h89180000, 4'd11, 16'h0004, 16'h0008);

    IR = 32'hC0000000;
    fetch("nop");
    push("nop.T3", ov(15'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0));
    ticks(4);

    IR = 32'hF8000000;
    fetch("ill");
    push("ill.T3", ov(15'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b1));
    ticks(4);

    // Stop raised mid-instruction: the add finishes, then strobes idle with Run held.
    IR   = 32'h18918000;
    Stop = 1'b1;
    fetch("stop");
    push("stop.T3", ov(B_YIN, 16'h0, 16'h0004, 4'd0, 1'b1, 1'b0));
    push("stop.T4", ov(B_ZIN, 16'h0, 16'h0008, 4'd0, 1'b1, 1'b0));
    push("stop.T5", ov(B_ZLOOUT, 16'h0002, 16'h0, 4'd0, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) push("stop.idle", ov(15'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0));
    ticks(9);
    Stop = 1'b0;
    push("stop.last_idle", ov(15'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0));
    ticks(1);

    IR = 32'h18918000;
    fetch("rstx");
    push("rstx.T3", ov(B_YIN, 16'h0, 16'h0004, 4'd0, 1'b1, 1'b0));
    ticks(4);
    Resetn = 1'b0;
    push("rstx.async", ov(15'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0));
    ticks(1);
    push("rstx.held", ov(15'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0));
    Resetn = 1'b1;
    ticks(1);

    IR = 32'hC8000000;
    fetch("halt");
    push("halt.T3", ov(15'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0));
    for (int i = 0; i < 20; i++) push("halt.hold", ov(15'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0));
    ticks(24);
    Resetn = 1'b0;
    push("halt.rst", ov(15'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0));
    ticks(1);
    Resetn = 1'b1;
    push("halt.rst_rel", ov(15'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0));
    ticks(1);

    alu_instr("and2", 32'h38918000, 1'b0, 4'd2, 16'h0002, 16'h0004, 16'h0008);

    for (int i = 0; i < 4 && sb.size() != 0; i++) ticks(1);
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d unchecked vectors, expected 0", sb.size());
      n_err += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the datapath's register-transfer strobes, one micro-step per clock. It sequences instruction fetch (T0–T2), decodes the instruction register returned by the datapath, and runs the execute steps (T3–T6) for register ALU, immediate, multiply/divide and unary instructions. It sits directly upstream of `datapath`: every enable it produces feeds the datapath's same-named `*in`/`*out` control inputs.

## Interface
- `NUM_REGS`, 16: general registers; sets the width of `Rin`/`Rout`.
- `OPC_W`, 5: opcode field width, `IR[31:27]`.
- `Clock` in 1: rising-edge clock.
- `Resetn` in 1: asynchronous, active-low reset.
- `Stop` in 1: when 1, the sequencer holds before the next fetch.
- `IR` in 32: instruction register from the datapath. Fields: `IR[26:23]` Ra, `IR[22:19]` Rb, `IR[18:15]` Rc, `IR[18:0]` C.
- `PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin, Cout` out 1 each: datapath strobes.
- `Rin` out NUM_REGS: one-hot register write enable.
- `Rout` out NUM_REGS: one-hot register bus drive.
- `ALUop` out 4: ALU function select.
- `Run` out 1: 1 while the core is executing; 0 in HALT.
- `Illegal` out 1: one-cycle pulse in T3 when the opcode is undefined.

## Operation
- Opcodes:
  - Register ALU: add 00011, sub 00100, or 00101, shr 00110, and 00111, shl 01000, ror 01001, rol 01010.
  - Immediate: addi 01011, andi 01100, ori 01101.
  - Multiply/divide: mul 01110, div 01111.
  - Unary: neg 10000, not 10001.
  - Control: nop 11000, halt 11001.
  - All other opcodes are illegal.
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALT.
- Fetch (every instruction):
  - T0: `PCout MARin IncPC Zin`.
  - T1: `ZLOout PCin Read MDRin`.
  - T2: `MDRout IRin`.
- Register ALU (`Ra ← Rb op Rc`):
  - T3: `Rout[Rb] Yin`.
  - T4: `Rout[Rc] ALUop Zin`.
  - T5: `ZLOout Rin[Ra]`.
  - Then T0.
- Immediate (`Ra ← Rb op sext(C)`): as register ALU, except T4 drives `Cout` instead of `Rout`. Sign extension of C is done in the datapath.
- mul/div (`HI:LO ← Ra op Rb`):
  - T3: `Rout[Ra] Yin`.
  - T4: `Rout[Rb] ALUop Zin`.
  - T5: `ZLOout LOin`.
  - T6: `ZHIout HIin`.
  - Then T0.
- neg/not (`Ra ← op Rb`):
  - T3: `Rout[Rb] ALUop Zin`.
  - T4: `ZLOout Rin[Ra]`.
  - Then T0.
- nop and illegal opcodes: from T3 go straight to T0. Illegal also pulses `Illegal` in T3.
- halt: T3 → HALT. HALT is held until `Resetn` is asserted; `Run`=0.
- `ALUop` encoding: ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHL 5, ROR 6, ROL 7, MUL 8, DIV 9, NEG 10, NOT 11. It is 0 whenever `Zin` is 0 or the state is T0.
- Output rules:
  - All outputs are Moore: decoded from the present state and the registered `IR` only.
  - `Rin` and `Rout` are each zero or one-hot, never both non-zero in the same cycle.
  - Outputs not listed for a state are 0.

## Timing
- One state per clock; transitions on the rising edge of `Clock`.
- Reset:
  - `Resetn`=0 forces RST immediately, mid-instruction included. All outputs go to 0; `Run` goes to 0.
  - The first rising edge after deassertion moves RST → T0.
  - `Run` is 1 in every state except RST and HALT.
- `Stop`:
  - Sampled only on the edge leaving the final execute step (or RST).
  - If `Stop`=1, the next state is RST-equivalent idle (all strobes 0, `Run`=1) until `Stop`=0.
  - An instruction already in progress always completes.
- `IR` timing: `IR` is latched by the datapath at the end of T2, so decode uses `IR` from T3 onward. `IR` is ignored in T0–T2.
- Cycles per instruction:
  - Register ALU and immediate: 6.
  - mul/div: 7.
  - neg/not: 5.
  - nop and illegal: 4.
- Sequencer state is 4 bits; there is no wrap-around. Unused encodings go to RST.

## Structure
- Package `cpu_pkg` holds:
  - opcode localparams;
  - the state enum (RST, T0–T6, HALT);
  - ALUop codes;
  - IR field bit positions.
- Sub-module `select_encode` takes Ra/Rb/Rc from `IR` plus `Gra`/`Grb`/`Grc`/`Rin_en`/`Rout_en` from the FSM, and produces the one-hot `Rin` and `Rout`.
- Top level is `control_sequencer`: the state register plus the output decode.

## Test plan
- **Reset then and.** Reset, then `IR`=0x38918000 (and R1,R2,R3) presented at T3.
  - T3: `Rout`=0x0004, `Yin`=1.
  - T4: `Rout`=0x0008, `ALUop`=2, `Zin`=1.
  - T5: `Rin`=0x0002, `ZLOout`=1.
  - Next cycle is T0 with `PCout MARin IncPC Zin`=1.
- **addi.** `IR`=0x58900005 (addi R1,R2,5).
  - T4: `Cout`=1, `Rout`=0, `ALUop`=0.
  - T5: `Rin`=0x0002.
- **mul.** `IR`=0x70900000 (mul R1,R2).
  - T5: `LOin`=1, `ZLOout`=1.
  - T6: `HIin`=1, `ZHIout`=1.
  - Total 7 cycles.
- **halt.** `IR`=0xC8000000.
  - State is HALT from the cycle after T3; `Run`=0; all strobes stay 0 for 20 cycles.
  - `Resetn` pulse → T0 two edges later.
- **Illegal opcode.** `IR`=0xF8000000.
  - `Illegal`=1 for exactly the T3 cycle; no `Rin`/`Rout`; next state is T0.
- **Reset during execute.** Assert `Resetn`=0 during T4 of an add.
  - All outputs are 0 within the same cycle (asynchronous).
  - After release, T0 is reached on the first edge.
  - `Stop`=1 held at the end of an instruction keeps every strobe at 0 until `Stop` is released.
